// File: rtl/mem_dump_reader.sv
// Post-run readback engine: sweeps a word range of data memory, streams each word
// over valid/ready through a 2-entry skid buffer, and checks a rotate-XOR signature.
module mem_dump_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [DATA_WIDTH-1:0] expect_sum,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  match
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic logic [DATA_WIDTH-1:0] rotl1(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
  endfunction

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_match;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic [DATA_WIDTH-1:0] r_expect;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_issued;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [ADDR_WIDTH-1:0] r_fifo_addr [2];
  logic                  r_fifo_last [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_occ;

  logic [1:0]            w_outstanding;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_last;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_head_last;
  logic                  w_out_valid;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_cs_next;

  // When the buffer is empty the returning read word is presented directly, so the
  // first word appears the cycle after its read; if it stalls it is captured below.
  always_comb begin
    w_outstanding = r_occ + {1'b0, r_inflight};
    w_rd_en       = (r_state == S_READ) && (w_outstanding < 2'd2);
    w_rd_addr     = r_base + r_issued[ADDR_WIDTH-1:0];
    w_rd_last     = ((r_issued + CNT_ONE) == r_count);
    w_fifo_empty  = (r_occ == 2'd0);
    w_head_data   = w_fifo_empty ? mem_rdata       : r_fifo_data[r_rd_ptr];
    w_head_addr   = w_fifo_empty ? r_inflight_addr : r_fifo_addr[r_rd_ptr];
    w_head_last   = w_fifo_empty ? r_inflight_last : r_fifo_last[r_rd_ptr];
    w_out_valid   = !w_fifo_empty || r_inflight;
    w_hs          = w_out_valid && out_ready;
    w_pop         = w_hs && !w_fifo_empty;
    w_push        = r_inflight && !(w_hs && w_fifo_empty);
    w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_cs_next     = rotl1(r_checksum) ^ w_head_data;
  end

  assign mem_rd_en = w_rd_en;
  assign mem_addr  = w_rd_en ? w_rd_addr : '0;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? w_head_data : '0;
  assign out_addr  = w_out_valid ? w_head_addr : '0;
  assign out_last  = w_out_valid && w_head_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign checksum  = r_checksum;
  assign match     = r_match;

  // Datapath registers: no reset, they are only consumed under control qualifiers.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base   <= base_addr;
      r_count  <= word_count;
      r_expect <= expect_sum;
    end
    if (w_rd_en) begin
      r_inflight_addr <= w_rd_addr;
      r_inflight_last <= w_rd_last;
    end
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_rdata;
      r_fifo_addr[r_wr_ptr] <= r_inflight_addr;
      r_fifo_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_checksum <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) r_issued <= r_issued + CNT_ONE;
      if (w_push)  r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)   r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_hs) r_checksum <= w_cs_next;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_checksum <= '0;
            r_issued   <= '0;
            if (word_count == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_match <= (expect_sum == '0);
            end else begin
              r_state <= S_READ;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_match <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (w_rd_en && w_rd_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_hs && w_head_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_match <= (w_cs_next == r_expect);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized scoreboard bench for mem_dump_reader: a memory model answers reads,
// expected words and read addresses are queued per sweep and checked by a monitor.
module tb_mem_dump_reader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [DW-1:0] expect_sum;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          match;

  always #5 clk = ~clk;

  mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .expect_sum(expect_sum), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done), .checksum(checksum),
    .match(match)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [DW+AW:0] prev_word;
  word_t         mon_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: reads checked against queued addresses, handshakes against queued words.
  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_word_held", {out_last, out_addr, out_data}, prev_word);
      end
      if (mem_rd_en) begin
        check("rd_outstanding_lt2", outstanding < 2, 1);
        check("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_w = exp_q.pop_front();
          check("out_data", out_data, mon_w.data);
          check("out_addr", out_addr, mon_w.addr);
          check("out_last", out_last, mon_w.last);
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_word   = {out_last, out_addr, out_data};
      outstanding = outstanding + int'(mem_rd_en) - int'(out_valid && out_ready);
    end
  end

  task automatic load_expect(input logic [AW-1:0] base, input logic [AW:0] cnt,
                             output logic [DW-1:0] cs);
    word_t         w;
    logic [AW-1:0] a;
    cs = '0;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + AW'(i);
      cs = ((cs << 1) | (cs >> (DW-1))) ^ mem[a];
      w.data = mem[a];
      w.addr = a;
      w.last = (i == int'(cnt) - 1);
      exp_q.push_back(w);
      addr_q.push_back(a);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data, 0);
    check({tag, "_out_addr"},  out_addr, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_checksum"},  checksum, 0);
    check({tag, "_match"},     match, 0);
  endtask

  // rmode: 0 = ready always high, 1 = fixed backpressure pattern, 2 = random ready
  task automatic sweep(input string tag, input logic [AW-1:0] base, input logic [AW:0] cnt,
                       input bit good_exp, input int rmode, input bit chk_t, input bit poke);
    logic [DW-1:0] cs;
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int first_rd  = -1;
    int first_vld = -1;
    int done_c    = -1;
    load_expect(base, cnt, cs);
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    expect_sum = good_exp ? cs : (cs ^ 32'h1);
    out_ready  = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (poke && k == 3) begin
        start      = 1'b1;
        base_addr  = '0;
        word_count = 1;
      end
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 1) out_ready = (k >= 2 && k <= 8) ? pat[k-2][0] : 1'b1;
      else                 out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (mem_rd_en && first_rd < 0) first_rd = k;
      if (out_valid && first_vld < 0) first_vld = k;
      if (k == 1) check({tag, "_busy_after_start"}, busy, cnt != 0);
      if (done) begin
        done_c = k;
        break;
      end
    end
    check({tag, "_done_reached"}, done_c > 0, 1);
    check({tag, "_checksum"}, checksum, cs);
    check({tag, "_match"}, match, good_exp);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_all_words_seen"}, exp_q.size(), 0);
    check({tag, "_all_reads_seen"}, addr_q.size(), 0);
    if (cnt == 0) begin
      check({tag, "_zero_no_read"}, first_rd == -1, 1);
      check({tag, "_zero_done_cycle"}, done_c, 1);
    end else if (chk_t) begin
      check({tag, "_first_rd_cycle"}, first_rd, 1);
      check({tag, "_first_vld_cycle"}, first_vld, 2);
      check({tag, "_done_cycle"}, done_c, int'(cnt) + 2);
    end
  endtask

  task automatic reset_mid();
    logic [DW-1:0] cs;
    int hs = 0;
    load_expect(10'h010, 4, cs);
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = 10'h010;
    word_count = 4;
    expect_sum = cs;
    out_ready  = 1'b1;
    for (int k = 1; k <= 20 && hs < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (out_valid && out_ready) hs++;
    end
    check("rst_mid_two_words", hs, 2);
    @(posedge clk); #1;
    reset      = 1'b1;
    out_ready  = 1'b0;
    start      = 1'b1;
    base_addr  = '0;
    word_count = 4;
    @(posedge clk); #1;
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_zero("rst_mid");
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_valid", out_valid, 0);
      check("rst_mid_no_read", mem_rd_en, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    expect_sum = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[10'h010] = 32'h11;
    mem[10'h011] = 32'h12;
    mem[10'h012] = 32'h13;
    mem[10'h013] = 32'h14;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");

    sweep("basic",    10'h010, 4, 1'b1, 0, 1'b1, 1'b0);
    check("basic_sig_f2", checksum, 32'hF2);
    sweep("mismatch", 10'h010, 4, 1'b0, 0, 1'b1, 1'b0);
    sweep("backpr",   10'h010, 4, 1'b1, 1, 1'b0, 1'b1);
    sweep("wrap",     10'h3FE, 4, 1'b1, 0, 1'b1, 1'b0);
    sweep("zero",     10'h000, 0, 1'b1, 0, 1'b1, 1'b0);
    reset_mid();
    sweep("after_rst", 10'h010, 4, 1'b1, 0, 1'b1, 1'b0);
    for (int r = 0; r < 12; r++) begin
      sweep("rand", AW'($urandom), (AW+1)'($urandom_range(0, 24)),
            1'($urandom_range(0, 1)), 2, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Post-run readback engine for the single-cycle CPU's data memory.
- The bench loads an image into memory and runs the CPU. After the run, this block sweeps a word range of memory and streams each word out over a valid/ready interface.
- While streaming, it accumulates a rotate-XOR checksum and compares it against an expected signature, giving a hardware pass/fail without hierarchical peeks.
- Sits beside the data memory on a dedicated read port; idle while the CPU runs.

Parameters:
ADDR_WIDTH, 10, word-address width of the memory read port
DATA_WIDTH, 32, memory word width; checksum width equals DATA_WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sweep; ignored while busy
base_addr  in  ADDR_WIDTH  first word address, sampled with start
word_count  in  ADDR_WIDTH+1  number of words to read (0..2^ADDR_WIDTH), sampled with start
expect_sum  in  DATA_WIDTH  expected checksum, sampled with start
mem_rd_en  out  1  read strobe to memory
mem_addr  out  ADDR_WIDTH  read word address
mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en (registered read)
out_valid  out  1  stream word available
out_ready  in  1  consumer accepts word
out_data  out  DATA_WIDTH  streamed word
out_addr  out  ADDR_WIDTH  address the word came from
out_last  out  1  high with final word
busy  out  1  sweep in progress
done  out  1  sweep complete, held until next accepted start or reset
checksum  out  DATA_WIDTH  running checksum
match  out  1  valid when done: checksum == latched expect_sum

Behaviour:
- Reset: all outputs 0, state IDLE, skid buffer empty, in-flight flag clear.
- States:
  - IDLE: start moves to READ, or to DONE directly if word_count==0.
  - READ: issues reads.
  - DRAIN: all reads issued, buffer not yet empty.
  - DONE.
  - From DONE, start is accepted the same way as from IDLE.
- Accepting start:
  - latches base, count, expect;
  - clears checksum, done and match;
  - sets busy the next cycle.
- Read issue:
  - mem_rd_en is high in READ only when (buffer occupancy + in-flight read) < 2.
  - Buffer is a 2-entry FIFO holding {data, addr, last}.
  - mem_addr = (base + issued_index) mod 2^ADDR_WIDTH; addresses wrap, no error.
- Return path: the word captured 1 cycle after mem_rd_en is pushed into the buffer. Overflow is impossible by the issue rule.
- Timing: with out_ready held high, start in cycle 0 gives:
  - first mem_rd_en in cycle 1;
  - first out_valid in cycle 2;
  - one word per cycle after that;
  - last word in cycle word_count+1.
- Stream rules:
  - out_valid is asserted while the buffer is non-empty.
  - out_data, out_addr and out_last are stable while out_valid && !out_ready.
  - Words are delivered in address order, with no drops or duplicates.
- Checksum: on each handshake (out_valid && out_ready), checksum <= rotl1(checksum) ^ out_data.
- Completion:
  - The handshake with out_last=1 sets done=1 and busy=0 and computes match, all visible the next cycle.
  - With word_count==0: done=1 the cycle after start, no mem_rd_en, checksum=0.
- reset mid-sweep: aborts at the next edge, returns to the reset state, and discards buffer contents and the in-flight word. mem_rd_en is low in the cycle after reset.
- start together with reset: reset wins.

Test Plan:
- Basic sweep: mem[0x10..0x13]=0x11,0x12,0x13,0x14; start base=0x10, count=4, expect=0xF2, out_ready=1.
  - Stream is 0x11..0x14, addrs 0x10..0x13, out_last on the 4th word.
  - done in cycle 6, checksum=0xF2, match=1.
- Mismatch: same setup with expect=0xF3 -> checksum=0xF2, match=0.
- Backpressure: out_ready pattern 1,0,0,1,0,1,1.
  - Same 4 words in order, data held stable while stalled, checksum=0xF2.
  - mem_rd_en never asserted when occupancy+in-flight = 2.
- Wrap: base=0x3FE, count=4 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001; out_addr matches.
- Zero count: start with count=0, expect=0 -> done=1 next cycle, no mem_rd_en, match=1.
- Reset mid-sweep: reset after the 2nd handshake of a 4-word sweep.
  - All outputs 0, no further out_valid.
  - A new start then yields a full correct stream.
